// File: rtl/fp32_div_seq.sv
// fp32_div_seq: iterative IEEE-754 single-precision divider, s = a / b.
// One quotient bit per cycle. Only one operation is in flight at a time.
// Special values, round-to-nearest-even and subnormal handling are bit-exact
// with the companion FP32 multiplier.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid & ready are both 1. The producer holds valid and its payload
// stable until that edge. The consumer may raise or drop ready at any time.
// in_ready is high only in IDLE. out_valid, s and out_flags stay stable in
// DONE until out_ready is seen.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset (highest priority)
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       dividend / divisor, FP32
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   s          quotient, FP32
//   out_flags  {invalid, div_by_zero, overflow}, valid with out_valid
//
// Latency from the accept edge to the first out_valid cycle: special cases
// 2 cycles (CLASS, DONE); all other operands 30 cycles
// (CLASS, 27 x DIV, ROUND, DONE).
module fp32_div_seq #(
  parameter bit SUBNORMAL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] s,
  output logic [2:0]  out_flags
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLASS = 3'd1,
    S_DIV   = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [31:0]       a_r, b_r, s_r;
  logic [2:0]        flags_r;
  logic              sign_r;
  logic signed [9:0] e_r;
  logic [23:0]       mb_r;
  logic [25:0]       rem_r;
  logic [26:0]       q_r;
  logic [4:0]        cnt_r;

  // Leading-zero count of a 24-bit mantissa (input is non-zero when used).
  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic found;
    lzc24 = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      lzc24 = lzc24 + 5'd1;
      end
    end
  endfunction

  // ---------------- classification (CLASS) ----------------
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sign_c;

  assign exp_a  = a_r[30:23];
  assign exp_b  = b_r[30:23];
  assign frac_a = a_r[22:0];
  assign frac_b = b_r[22:0];
  assign sign_c = a_r[31] ^ b_r[31];
  assign a_nan  = (exp_a == 8'hFF) && (frac_a != 23'd0);
  assign a_inf  = (exp_a == 8'hFF) && (frac_a == 23'd0);
  assign a_zero = (exp_a == 8'h00) && ((frac_a == 23'd0) || !SUBNORMAL_EN);
  assign b_nan  = (exp_b == 8'hFF) && (frac_b != 23'd0);
  assign b_inf  = (exp_b == 8'hFF) && (frac_b == 23'd0);
  assign b_zero = (exp_b == 8'h00) && ((frac_b == 23'd0) || !SUBNORMAL_EN);

  logic        special;
  logic [31:0] special_s;
  logic [2:0]  special_f;

  always_comb begin
    special   = 1'b1;
    special_s = 32'd0;
    special_f = 3'b000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_s = {sign_c, 8'hFF, 23'h400000};
      special_f = 3'b100;
    end else if (b_zero && !a_inf) begin
      special_s = {sign_c, 8'hFF, 23'h0};
      special_f = 3'b010;
    end else if (a_inf) begin
      // inf / finite, zero divisor included
      special_s = {sign_c, 8'hFF, 23'h0};
    end else if (a_zero || b_inf) begin
      special_s = {sign_c, 31'h0};
    end else begin
      special = 1'b0;
    end
  end

  // Normalise mantissas; a subnormal's effective exponent is 1 - lz.
  logic [23:0]       ma_raw, mb_raw, ma_norm, mb_norm;
  logic [4:0]        lz_a, lz_b;
  logic signed [9:0] ea, eb, e_c;

  always_comb begin
    ma_raw  = {exp_a != 8'h00, frac_a};
    mb_raw  = {exp_b != 8'h00, frac_b};
    lz_a    = lzc24(ma_raw);
    lz_b    = lzc24(mb_raw);
    ma_norm = ma_raw << lz_a;
    mb_norm = mb_raw << lz_b;
    ea      = ((exp_a == 8'h00) ? 10'sd1 : $signed({2'b00, exp_a})) - $signed({5'b00000, lz_a});
    eb      = ((exp_b == 8'h00) ? 10'sd1 : $signed({2'b00, exp_b})) - $signed({5'b00000, lz_b});
    e_c     = ea - eb + 10'sd127;
  end

  // ---------------- restoring division step (DIV) ----------------
  logic        ge;
  logic [25:0] rem_sub, rem_next;

  always_comb begin
    ge       = rem_r >= {2'b00, mb_r};
    rem_sub  = ge ? (rem_r - {2'b00, mb_r}) : rem_r;
    rem_next = {rem_sub[24:0], 1'b0};
  end

  // ---------------- normalise / round / pack (ROUND) ----------------
  logic [26:0]       sig, shifted;
  logic signed [9:0] en, sh, ef;
  logic [4:0]        shamt;
  logic [53:0]       wide;
  logic              tiny, sticky, guard_b, round_b, lsb, up;
  logic [24:0]       m_r;
  logic [31:0]       round_s;
  logic [2:0]        round_f;

  always_comb begin
    if (q_r[26]) begin
      sig = q_r;
      en  = e_r;
    end else begin
      sig = {q_r[25:0], 1'b0};
      en  = e_r - 10'sd1;
    end
    tiny  = en <= 10'sd0;
    sh    = 10'sd1 - en;
    shamt = 5'd0;
    if (tiny && SUBNORMAL_EN) shamt = (sh > 10'sd26) ? 5'd26 : sh[4:0];
    // Bits shifted past the sticky position are collected in wide[26:0].
    wide    = {sig, 27'd0} >> shamt;
    shifted = wide[53:27];
    sticky  = (rem_r != 26'd0) || (wide[26:0] != 27'd0) || shifted[0];
    guard_b = shifted[2];
    round_b = shifted[1];
    lsb     = shifted[3];
    up      = guard_b && (round_b || sticky || lsb);
    m_r     = {1'b0, shifted[26:3]} + {24'd0, up};
    ef      = en + $signed({9'd0, m_r[24]});
    round_f = 3'b000;
    if (tiny) begin
      // A round-up into bit 23 lands in the exponent field as 1 (2^-126).
      if (SUBNORMAL_EN) round_s = {sign_r, 7'd0, m_r[23:0]};
      else              round_s = {sign_r, 31'h0};
    end else if (ef >= 10'sd255) begin
      round_s = {sign_r, 8'hFF, 23'h0};
      round_f = 3'b001;
    end else begin
      round_s = {sign_r, ef[7:0], m_r[24] ? 23'd0 : m_r[22:0]};
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid) state_next = S_CLASS;
      S_CLASS: state_next = special ? S_DONE : S_DIV;
      S_DIV:   if (cnt_r == 5'd26) state_next = S_ROUND;
      S_ROUND: state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      s_r     <= 32'd0;
      flags_r <= 3'b000;
      sign_r  <= 1'b0;
      e_r     <= 10'sd0;
      mb_r    <= 24'd0;
      rem_r   <= 26'd0;
      q_r     <= 27'd0;
      cnt_r   <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
          end
        end
        S_CLASS: begin
          sign_r <= sign_c;
          e_r    <= e_c;
          rem_r  <= {2'b00, ma_norm};
          mb_r   <= mb_norm;
          q_r    <= 27'd0;
          cnt_r  <= 5'd0;
          if (special) begin
            s_r     <= special_s;
            flags_r <= special_f;
          end
        end
        S_DIV: begin
          rem_r <= rem_next;
          q_r   <= {q_r[25:0], ge};
          cnt_r <= cnt_r + 5'd1;
        end
        S_ROUND: begin
          s_r     <= round_s;
          flags_r <= round_f;
        end
        S_DONE: begin
          if (out_ready) flags_r <= 3'b000;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign s         = s_r;
  assign out_flags = flags_r;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Testbench for fp32_div_seq: directed vectors, backpressure hold, reset in
// mid-division, flush-to-zero instance, and randomized operands checked
// against a real-arithmetic reference model.
module tb_fp32_div_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with subnormal support
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        in_ready, out_valid;
  logic [31:0] s;
  logic [2:0]  out_flags;

  fp32_div_seq #(.SUBNORMAL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .out_flags(out_flags)
  );

  // Flush-to-zero instance
  logic        in_valid0 = 1'b0, out_ready0 = 1'b1;
  logic [31:0] a0 = 32'd0, b0 = 32'd0;
  logic        in_ready0, out_valid0;
  logic [31:0] s0;
  logic [2:0]  out_flags0;

  fp32_div_seq #(.SUBNORMAL_EN(1'b0)) dut_ftz (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0),
    .s(s0), .out_flags(out_flags0)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int or_mode = 0;  // 0: out_ready=1, 1: random, 2: out_ready=0

  logic [34:0] exp_q[$];  // {flags, s}
  int          lat_q[$];
  int          acc_q[$];
  bit          seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r * 0.5;
    return r;
  endfunction

  function automatic real mag(input logic [31:0] x);
    int m, e;
    if (x[30:23] == 8'd0) begin
      m = int'(x[22:0]);
      e = -149;
    end else begin
      m = int'({1'b1, x[22:0]});
      e = int'(x[30:23]) - 150;
    end
    return real'(m) * pow2(e);
  endfunction

  // Exact quotient rounded to double, then RNE to FP32; the double step
  // carries more than twice the target precision, so no double-rounding.
  task automatic model(input logic [31:0] x, input logic [31:0] y, input bit sub_en,
                       output logic [31:0] rs, output logic [2:0] rf, output bit sp);
    logic sgn, xn, xi, xz, yn, yi, yz, g, st, up;
    logic [63:0] d, dm;
    logic [23:0] mant;
    logic [24:0] m25;
    int e2, sh;
    real q;
    sgn = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    xz = (x[30:23] == 8'h00) && ((x[22:0] == 0) || !sub_en);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    yz = (y[30:23] == 8'h00) && ((y[22:0] == 0) || !sub_en);
    rf = 3'b000;
    sp = 1'b1;
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      rs = {sgn, 8'hFF, 23'h400000}; rf = 3'b100;
    end else if (yz && !xi) begin
      rs = {sgn, 8'hFF, 23'h0}; rf = 3'b010;
    end else if (xi) begin
      rs = {sgn, 8'hFF, 23'h0};
    end else if (xz || yi) begin
      rs = {sgn, 31'h0};
    end else begin
      sp = 1'b0;
      q  = mag(x) / mag(y);
      d  = $realtobits(q);
      e2 = int'(d[62:52]) - 1023;
      dm = {11'd0, 1'b1, d[51:0]};
      if (e2 >= -126) begin
        mant = dm[52:29];
        g    = dm[28];
        st   = |dm[27:0];
        up   = g & (st | mant[0]);
        m25  = {1'b0, mant} + {24'd0, up};
        if (m25[24]) begin
          e2  = e2 + 1;
          m25 = 25'h0800000;
        end
        if (e2 > 127) begin
          rs = {sgn, 8'hFF, 23'h0}; rf = 3'b001;
        end else begin
          rs = {sgn, 8'(e2 + 127), m25[22:0]};
        end
      end else if (!sub_en) begin
        rs = {sgn, 31'h0};
      end else begin
        sh = -e2 - 97;  // units of 2^-149
        if (sh >= 54) m25 = 25'd0;
        else begin
          mant = 24'(dm >> sh);
          g    = dm[sh-1];
          st   = (dm & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0;
          up   = g & (st | mant[0]);
          m25  = {1'b0, mant} + {24'd0, up};
        end
        rs = {sgn, 31'(m25)};
      end
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() == 0});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", {63'd0, out_valid}, 64'd0);
        end else begin
          check("result", {29'd0, out_flags, s}, {29'd0, exp_q[0]});
          if (!seen) begin
            check("latency", 64'(cyc - acc_q[0] + 1), 64'(lat_q[0]));
            seen = 1'b1;
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // out_ready driver
  initial forever begin
    @(posedge clk);
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    seen = 1'b0;
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] rs;
    logic [2:0]  rf;
    bit          sp;
    int          n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      return;
    end
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    model(x, y, 1'b1, rs, rf, sp);
    exp_q.push_back({rf, rs});
    lat_q.push_back(sp ? 2 : 30);
    acc_q.push_back(cyc);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 64'(exp_q.size()), 64'd0);
      do_reset(1);
    end
  endtask

  task automatic run_ftz(input logic [31:0] x, input logic [31:0] y, input logic [34:0] lit);
    logic [31:0] rs;
    logic [2:0]  rf;
    bit          sp;
    int          acc, n;
    model(x, y, 1'b0, rs, rf, sp);
    check("ftz_model_pin", {29'd0, rf, rs}, {29'd0, lit});
    @(negedge clk);
    n = 0;
    while (!in_ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    a0 = x;
    b0 = y;
    in_valid0 = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid0 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("ftz_result", {29'd0, out_flags0, s0}, {29'd0, rf, rs});
    check("ftz_latency", 64'(cyc - acc + 1), sp ? 64'd2 : 64'd30);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v = $urandom;
    case ($urandom_range(0, 15))
      0:  v[30:0]  = 31'd0;
      1:  v[30:23] = 8'd0;
      2:  v[30:0]  = {8'hFF, 23'd0};
      3:  begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      4:  v[30:23] = 8'($urandom_range(1, 12));
      5:  v[30:23] = 8'($urandom_range(242, 254));
      6:  begin v[30:23] = 8'($urandom_range(120, 134)); v[15:0] = 16'd0; end
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // Directed vectors with hand-computed results {flags, s}
  logic [31:0] dir_a [12] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                              32'h00000000, 32'h7F7FFFFF, 32'h00800000, 32'h00000001,
                              32'hFF800000, 32'h3F800000, 32'h7F800001, 32'h00000001};
  logic [31:0] dir_b [12] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h80000000,
                              32'h00000000, 32'h00800000, 32'h40000000, 32'h00000001,
                              32'h00000000, 32'h7F800000, 32'h3F800000, 32'h3F000000};
  logic [34:0] dir_e [12] = '{{3'b000, 32'h40400000}, {3'b000, 32'h3EAAAAAB},
                              {3'b000, 32'hBEAAAAAB}, {3'b010, 32'hFF800000},
                              {3'b100, 32'h7FC00000}, {3'b001, 32'h7F800000},
                              {3'b000, 32'h00400000}, {3'b000, 32'h3F800000},
                              {3'b000, 32'hFF800000}, {3'b000, 32'h00000000},
                              {3'b100, 32'h7FC00000}, {3'b000, 32'h00000002}};

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rs;
    logic [2:0]  rf;
    bit          sp;
    int          n;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_s", {32'd0, s}, 64'd0);
    check("reset_flags", {61'd0, out_flags}, 64'd0);

    // Directed: pin the model, then run each vector through the DUT
    or_mode = 0;
    for (int i = 0; i < 12; i++) begin
      model(dir_a[i], dir_b[i], 1'b1, rs, rf, sp);
      check($sformatf("model_pin_%0d", i), {29'd0, rf, rs}, {29'd0, dir_e[i]});
      issue(dir_a[i], dir_b[i]);
      wait_done();
    end

    // Backpressure: hold out_ready low for 10 cycles in DONE
    or_mode = 2;
    repeat (2) @(posedge clk);
    issue(32'h40C00000, 32'h40000000);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("hold_s", {32'd0, s}, {32'd0, 32'h40400000});
      check("hold_flags", {61'd0, out_flags}, 64'd0);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    or_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check("release_out_valid", {63'd0, out_valid}, 64'd0);
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    wait_done();

    // Flush-to-zero instance
    run_ftz(32'h00800000, 32'h40000000, {3'b000, 32'h00000000});
    run_ftz(32'h00000001, 32'h3F800000, {3'b000, 32'h00000000});
    run_ftz(32'h3F800000, 32'h00000001, {3'b010, 32'h7F800000});
    run_ftz(32'h00000001, 32'h00000001, {3'b100, 32'h7FC00000});
    run_ftz(32'h40C00000, 32'h40000000, {3'b000, 32'h40400000});

    // Reset during DIV cycle 12: nothing must come out
    issue(32'h3F800000, 32'h40400000);
    repeat (12) @(posedge clk);
    do_reset(1);
    @(negedge clk);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (40) @(negedge clk);
    issue(32'hBF800000, 32'h40400000);
    wait_done();

    // Randomized operands with random backpressure and gaps
    or_mode = 1;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue(rand_fp(), rand_fp());
      wait_done();
    end
    or_mode = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp32_div_seq.md
Name: fp32_div_seq

Overview:
- Iterative IEEE-754 single-precision divider; computes s = a / b. It is the inverse operation of the combinational FP32 multiplier used in the VGG16 datapath.
- Serves the normalisation and averaging stages. Input and output each use a valid/ready handshake.
- Produces one quotient bit per cycle. Only one operation is in flight at a time.
- Special-value encoding, rounding and subnormal handling match the multiplier, so mul/div results compare bit-exactly.

Parameters:
- SUBNORMAL_EN, 1: 1 = full subnormal support on inputs and outputs. 0 = subnormal inputs are treated as signed zero, and results below 2^-126 flush to signed zero.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  32  dividend, FP32
- b  input  32  divisor, FP32
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  32  quotient, FP32
- out_flags  output  3  {invalid, div_by_zero, overflow}, valid with out_valid

Behaviour:
- Reset: sampled on a clk rising edge while rst=1. Forces state IDLE, in_ready=1, out_valid=0, s=0, out_flags=0. Any operation in progress is discarded with no output. rst has priority over every other input.
- Accept: a handshake occurs when in_valid & in_ready at a rising edge. a and b are registered on that edge. The input bus is don't-care afterwards.
- States:
  - IDLE: wait for accept, then go to CLASS.
  - CLASS (1 cycle): decode special cases.
    - Special case → go to DONE with the result loaded.
    - Otherwise, normalise subnormal mantissas with a leading-zero count, form the 10-bit signed exponent, then go to DIV.
  - DIV (27 cycles): restoring division of the 24-bit mantissas; 27 quotient bits, q[26] weighs 2^0.
  - ROUND (1 cycle): normalise, round, pack; then go to DONE.
  - DONE: hold out_valid=1 with s and out_flags stable until out_ready=1, then go to IDLE. No new operand is accepted in DONE.
- Latency, counted from the accept edge to the first cycle out_valid=1:
  - special cases: 2 cycles
  - all other operands: 30 cycles
  - latency is independent of out_ready; backpressure only extends DONE.
- Sign: a[31]^b[31], applied to every result including zero, infinity and NaN.
- Special cases, in priority order:
  - either operand NaN, 0/0, or inf/inf → NaN {sign, 8'hFF, 23'h400000}; invalid=1
  - x/0 with x finite and non-zero → {sign, 8'hFF, 0}; div_by_zero=1
  - inf/finite → infinity, no flag
  - 0/non-zero or finite/inf → signed zero, no flag
- Exponent arithmetic:
  - effective input exponent = exponent field for normals; 1 − lz for subnormals, where lz is the left shift applied to the mantissa.
  - e = ea − eb + 127, held as 10-bit two's complement.
  - if q[26]=0: shift q left by 1 and decrement e.
- Rounding: round-to-nearest-even using guard, round and sticky. Sticky = OR of the leftover quotient bits and (remainder ≠ 0). A mantissa carry-out increments e.
- Overflow: e ≥ 255 after rounding → infinity; overflow=1.
- Underflow (SUBNORMAL_EN=1): e ≤ 0 → right-shift the significand by 1−e (capped at 26) into sticky, then round. The result exponent field is 0; a round-up to 2^-126 yields exponent field 1.
- Underflow (SUBNORMAL_EN=0): e ≤ 0 → signed zero.
- out_flags clears when leaving DONE.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2), out_ready=1 → s=0x40400000 exactly 30 cycles after accept, flags=0, in_ready low throughout.
- 0x3F800000 / 0x40400000 (1/3) → s=0x3EAAAAAB (round-up via sticky). Also 0xBF800000 / 0x40400000 → 0xBEAAAAAB.
- 0x3F800000 / 0x80000000 → s=0xFF800000, flags=3'b010, latency 2. 0x00000000 / 0x00000000 → s=0x7FC00000, flags=3'b100.
- 0x7F7FFFFF / 0x00800000 → s=0x7F800000, flags=3'b001. 0x00800000 / 0x40000000 → s=0x00400000 (SUBNORMAL_EN=1) and s=0x00000000 (SUBNORMAL_EN=0).
- Subnormal dividend 0x00000001 / 0x00000001 → s=0x3F800000.
- Hold out_ready=0 for 10 cycles after out_valid → s and out_flags stable, in_ready=0. Release → out_valid drops next cycle and in_ready=1.
- Assert rst for 1 cycle at DIV cycle 12 → next cycle out_valid=0, in_ready=1, no result emitted. A new accept then completes normally.
